// File: rtl/mips_16_scan_ctrl.sv
// Scan sequencer for the two mips_16 core scan chains: streams 2-bit stimulus in,
// responses out, and gates the core clock around shift/capture.
module mips_16_scan_ctrl #(
  parameter int CHAIN_LEN   = 64,
  parameter int NUM_CAPTURE = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic             in_valid,
  input  logic [1:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [1:0]       out_data,
  input  logic             out_ready,
  output logic             test_se,
  output logic             test_si1,
  output logic             test_si2,
  input  logic             test_so1,
  input  logic             test_so2,
  output logic             core_clk_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pat_cnt
);

  localparam int SC_W  = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int CAP_W = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRE    = 3'd1,
    S_SHIFT  = 3'd2,
    S_SETTLE = 3'd3,
    S_CAPT   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic               flush_q, flush_d;
  logic               unload_q, unload_d;
  logic [SC_W-1:0]    shift_cnt_q, shift_cnt_d;
  logic [CAP_W-1:0]   cap_cnt_q, cap_cnt_d;
  logic [CNT_W-1:0]   pat_cnt_q, pat_cnt_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic               test_se_q, test_se_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               clk_en_q, clk_en_d;
  logic               in_shift_s;
  logic               go_s;

  assign in_shift_s = (state_q == S_SHIFT);
  assign go_s       = (in_valid | flush_q) & (out_ready | ~unload_q);

  // In SHIFT the core clock tracks the handshake so a stall freezes the chains.
  assign core_clk_en = in_shift_s ? go_s : clk_en_q;
  assign in_ready    = in_shift_s & go_s & ~flush_q;
  assign out_valid   = in_shift_s & (in_valid | flush_q) & unload_q;
  assign out_data    = {test_so2, test_so1};
  assign test_si1    = (in_shift_s & ~flush_q) ? in_data[0] : 1'b0;
  assign test_si2    = (in_shift_s & ~flush_q) ? in_data[1] : 1'b0;
  assign test_se     = test_se_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pat_cnt     = pat_cnt_q;

  always_comb begin
    state_d     = state_q;
    flush_d     = flush_q;
    unload_d    = unload_q;
    shift_cnt_d = shift_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    pat_cnt_d   = pat_cnt_q;
    num_d       = num_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pat_cnt_d = '0;
          if (num_patterns != '0) begin
            state_d  = S_PRE;
            num_d    = num_patterns;
            unload_d = 1'b0;
            flush_d  = 1'b0;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRE: begin
        state_d     = S_SHIFT;
        shift_cnt_d = '0;
      end
      S_SHIFT: begin
        if (go_s) begin
          if (shift_cnt_q == SC_W'(CHAIN_LEN - 1)) begin
            state_d = flush_q ? S_DONE : S_SETTLE;
          end else begin
            shift_cnt_d = shift_cnt_q + SC_W'(1);
          end
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_SETTLE: begin
        state_d   = S_CAPT;
        cap_cnt_d = '0;
      end
      S_CAPT: begin
        if (cap_cnt_q == CAP_W'(NUM_CAPTURE - 1)) begin
          pat_cnt_d = pat_cnt_q + CNT_W'(1);
          unload_d  = 1'b1;
          flush_d   = ((pat_cnt_q + CNT_W'(1)) == num_q);
          state_d   = S_PRE;
        end else begin
          cap_cnt_d = cap_cnt_q + CAP_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet align with it.
  always_comb begin
    test_se_d = 1'b0;
    clk_en_d  = 1'b1;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    case (state_d)
      S_PRE:    begin test_se_d = 1'b1; clk_en_d = 1'b0; end
      S_SHIFT:  begin test_se_d = 1'b1; clk_en_d = 1'b0; end
      S_SETTLE: begin test_se_d = 1'b0; clk_en_d = 1'b0; end
      default:  begin test_se_d = 1'b0; clk_en_d = 1'b1; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      flush_q     <= 1'b0;
      unload_q    <= 1'b0;
      shift_cnt_q <= '0;
      cap_cnt_q   <= '0;
      pat_cnt_q   <= '0;
      num_q       <= '0;
      test_se_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      clk_en_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      flush_q     <= flush_d;
      unload_q    <= unload_d;
      shift_cnt_q <= shift_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      pat_cnt_q   <= pat_cnt_d;
      num_q       <= num_d;
      test_se_q   <= test_se_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      clk_en_q    <= clk_en_d;
    end
  end

endmodule

// File: tb/tb_mips_16_scan_ctrl.sv
// Bench for mips_16_scan_ctrl: a 4-bit two-chain core model whose capture inverts
// the chains, with a scoreboard of expected unload beats.
module tb_mips_16_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_patterns = 16'd0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_data = 2'd0;
  logic        in_ready;
  logic        out_valid;
  logic [1:0]  out_data;
  logic        out_ready = 1'b1;
  logic        test_se, test_si1, test_si2, test_so1, test_so2;
  logic        core_clk_en, busy, done;
  logic [15:0] pat_cnt;

  logic [3:0]  ch1 = 4'd0;
  logic [3:0]  ch2 = 4'd0;

  int          total = 0;
  int          bad = 0;
  logic [1:0]  exp_q[$];
  int          in_cnt = 0, out_cnt = 0, done_cnt = 0, stall_cnt = 0;
  bit          se_seen = 1'b0;
  bit          iv_toggle = 1'b0;
  int          or_hold = 0;
  int          edges;

  mips_16_scan_ctrl #(.CHAIN_LEN(4), .NUM_CAPTURE(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .num_patterns(num_patterns),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .test_se(test_se), .test_si1(test_si1), .test_si2(test_si2),
    .test_so1(test_so1), .test_so2(test_so2), .core_clk_en(core_clk_en),
    .busy(busy), .done(done), .pat_cnt(pat_cnt)
  );

  always #5 clk = ~clk;

  assign test_so1 = ch1[3];
  assign test_so2 = ch2[3];

  // Core model: shift MSB-out when scan-enabled, invert on a capture clock.
  always @(posedge clk) begin
    if (core_clk_en) begin
      if (test_se) begin
        ch1 <= {ch1[2:0], test_si1};
        ch2 <= {ch2[2:0], test_si2};
      end else begin
        ch1 <= ~ch1;
        ch2 <= ~ch2;
      end
    end
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Stimulus driver: new beat data each cycle, optional valid toggling and sink back-pressure.
  always @(posedge clk) begin
    #1;
    in_valid  = iv_toggle ? ~in_valid : 1'b1;
    in_data   = 2'($urandom_range(0, 3));
    out_ready = (or_hold == 0);
    if (or_hold > 0) or_hold--;
  end

  // Monitor: handshakes seen at the falling edge complete on the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (test_se) se_seen = 1'b1;
      if (done) done_cnt++;
      if (in_valid && in_ready) begin
        check_val("si_bits", {test_si2, test_si1}, in_data);
        exp_q.push_back(~in_data);
        in_cnt++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_val("sb_underflow", exp_q.size(), 1);
        else check_val("out_beat", out_data, exp_q.pop_front());
        out_cnt++;
      end
      if (out_valid && !out_ready) begin
        check_val("stall_clk_en", core_clk_en, 0);
        check_val("stall_in_ready", in_ready, 0);
        stall_cnt++;
      end
    end
  end

  // Called just after a rising edge; returns edges from start sampling to done seen.
  task automatic run_seq(input int n, input int mode, output int e);
    bit seen = 1'b0;
    bit stalled = 1'b0;
    in_cnt = 0; out_cnt = 0; done_cnt = 0; stall_cnt = 0; se_seen = 1'b0;
    start = 1'b1;
    num_patterns = n[15:0];
    @(posedge clk); #1;
    start = 1'b0;
    e = 1;
    while (!seen && e < 400) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
      end else begin
        if (mode == 2 && out_valid && !stalled) begin
          or_hold = 3;
          stalled = 1'b1;
        end
        @(posedge clk); #1;
        e++;
        if (mode == 1 && e == 3) begin start = 1'b1; num_patterns = 16'd7; end
        if (mode == 1 && e == 4) start = 1'b0;
      end
    end
    check_val("done_seen", seen, 1);
    @(posedge clk);
    @(negedge clk);
    check_val("done_one_cycle", done, 0);
    check_val("busy_after_done", busy, 0);
    check_val("sb_drained", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #12;
    check_val("rst_se", test_se, 0);
    check_val("rst_clk_en", core_clk_en, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_pat_cnt", pat_cnt, 0);
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    run_seq(0, 0, edges);
    check_val("np0_latency", edges, 1);
    check_val("np0_no_se", se_seen, 0);
    check_val("np0_in_beats", in_cnt, 0);
    check_val("np0_pat_cnt", pat_cnt, 0);

    run_seq(1, 0, edges);
    check_val("np1_latency", edges, 13);
    check_val("np1_in_beats", in_cnt, 4);
    check_val("np1_out_beats", out_cnt, 4);
    check_val("np1_pat_cnt", pat_cnt, 1);
    check_val("np1_done_pulses", done_cnt, 1);

    run_seq(3, 1, edges);
    check_val("np3_in_beats", in_cnt, 12);
    check_val("np3_out_beats", out_cnt, 12);
    check_val("np3_pat_cnt", pat_cnt, 3);

    iv_toggle = 1'b1;
    run_seq(2, 2, edges);
    iv_toggle = 1'b0;
    check_val("stall_seen", int'(stall_cnt > 0), 1);
    check_val("stall_in_beats", in_cnt, 8);
    check_val("stall_out_beats", out_cnt, 8);
    check_val("stall_pat_cnt", pat_cnt, 2);

    // Asynchronous reset in the middle of the first load.
    in_cnt = 0; done_cnt = 0;
    start = 1'b1;
    num_patterns = 16'd2;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 50 && in_cnt < 2; i++) @(negedge clk);
    check_val("mid_beats", in_cnt, 2);
    #1 rst = 1'b1;
    #1;
    check_val("mid_rst_se", test_se, 0);
    check_val("mid_rst_clk_en", core_clk_en, 1);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_in_ready", in_ready, 0);
    check_val("mid_rst_pat_cnt", pat_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    done_cnt = 0;
    repeat (20) @(negedge clk);
    check_val("mid_rst_no_done", done_cnt, 0);
    check_val("mid_rst_idle", busy, 0);
    @(posedge clk); #1;

    run_seq(1, 0, edges);
    check_val("recover_latency", edges, 13);
    check_val("recover_out_beats", out_cnt, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
